// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz from a 100 MHz system clock)
// and small helpers used by the sync generator and pixel-rate logic.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int CLK_DIV_DEF   = 4;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Inclusive window test on unsigned 10-bit counts.
    function automatic logic in_window(input coord_t cnt, input coord_t first, input coord_t last);
        return (cnt >= first) && (cnt <= last);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock divider: a counter running 0..CLK_DIV-1 with a one-clock strobe
// on the final count, shared by anything that runs at pixel rate.
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;

    // Next divider count: wrap after the last count.
    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
    end

    // Divider register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

    assign tick = (div_cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, registered syncs and video_on
// aligned with the counters, end-of-line/frame strobes and a frame counter.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pixel_tick,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_end,
    output logic        frame_end,
    output logic [15:0] frame_count
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    coord_t      h_cnt_q, h_cnt_d;
    coord_t      v_cnt_q, v_cnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic        started_q, started_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        h_last, v_last;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_pixel_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (pixel_tick)
    );

    assign h_last    = (h_cnt_q == H_LAST);
    assign v_last    = (v_cnt_q == V_LAST);
    assign line_end  = pixel_tick & h_last;
    assign frame_end = line_end & v_last;

    // Next-state counters; syncs and video_on are derived from the next
    // counts so their registers line up with pixel_x/pixel_y.
    // The reset position is the last pixel of a frame, so the frame_end seen
    // on the first tick after reset is not a real frame and is not counted.
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        started_d = started_q | pixel_tick;
        if (pixel_tick) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + coord_t'(1);
            end else begin
                h_cnt_d = h_cnt_q + coord_t'(1);
            end
        end
        hsync_d     = ~in_window(h_cnt_d, HS_FIRST, HS_LAST);
        vsync_d     = ~in_window(v_cnt_d, VS_FIRST, VS_LAST);
        video_on_d  = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        frame_cnt_d = (frame_end && started_q) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Raster state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q     <= H_LAST;
            v_cnt_q     <= V_LAST;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            video_on_q  <= 1'b0;
            started_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            started_q   <= started_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, CLK_DIV=2, and a
// tiny raster with CLK_DIV=3 so whole frames fit in a short run), all checked
// every cycle against a raster-position model plus directed literal checks.
module tb_vga_sync_gen;
    localparam int NDUT = 3;
    localparam int DIV [NDUT] = '{4, 2, 3};
    localparam int HD  [NDUT] = '{640, 640, 16};
    localparam int HF  [NDUT] = '{16, 16, 2};
    localparam int HS  [NDUT] = '{96, 96, 4};
    localparam int HB  [NDUT] = '{48, 48, 3};
    localparam int VD  [NDUT] = '{480, 480, 10};
    localparam int VF  [NDUT] = '{10, 10, 2};
    localparam int VS  [NDUT] = '{2, 2, 2};
    localparam int VB  [NDUT] = '{33, 33, 3};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        tk [NDUT];
    logic [9:0]  px [NDUT];
    logic [9:0]  py [NDUT];
    logic        hs [NDUT];
    logic        vs [NDUT];
    logic        vo [NDUT];
    logic        le [NDUT];
    logic        fe [NDUT];
    logic [15:0] fc [NDUT];

    vga_sync_gen dut_a (
        .clk(clk), .reset(rst), .pixel_tick(tk[0]), .pixel_x(px[0]), .pixel_y(py[0]),
        .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]), .line_end(le[0]),
        .frame_end(fe[0]), .frame_count(fc[0]));

    vga_sync_gen #(.CLK_DIV(2)) dut_b (
        .clk(clk), .reset(rst), .pixel_tick(tk[1]), .pixel_x(px[1]), .pixel_y(py[1]),
        .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]), .line_end(le[1]),
        .frame_end(fe[1]), .frame_count(fc[1]));

    vga_sync_gen #(.CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
                   .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_c (
        .clk(clk), .reset(rst), .pixel_tick(tk[2]), .pixel_x(px[2]), .pixel_y(py[2]),
        .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]), .line_end(le[2]),
        .frame_end(fe[2]), .frame_count(fc[2]));

    int n;               // clk edges since reset release
    int base [NDUT];     // frame_count offset introduced by fast-forward
    int total = 0;
    int bad   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    function automatic int htot(input int id);
        return HD[id] + HF[id] + HS[id] + HB[id];
    endfunction

    function automatic int vtot(input int id);
        return VD[id] + VF[id] + VS[id] + VB[id];
    endfunction

    // Completed frames: the frame_end on the first tick out of reset is not one.
    function automatic int frames_raw(input int id);
        int k;
        k = n / DIV[id];
        return (k == 0) ? 0 : (k - 1) / (htot(id) * vtot(id));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: after k ticks the raster sits at linear index (F-1+k) mod F.
    task automatic check_dut(input int id);
        int ht, vt, f, k, l, ex, ey, efc;
        bit etk, ehs, evs, evo, ele, efe;
        ht  = htot(id);
        vt  = vtot(id);
        f   = ht * vt;
        k   = n / DIV[id];
        etk = (n % DIV[id]) == DIV[id] - 1;
        l   = (f - 1 + k) % f;
        ex  = l % ht;
        ey  = l / ht;
        ehs = !(ex >= HD[id] + HF[id] && ex < HD[id] + HF[id] + HS[id]);
        evs = !(ey >= VD[id] + VF[id] && ey < VD[id] + VF[id] + VS[id]);
        evo = (ex < HD[id]) && (ey < VD[id]);
        ele = etk && (ex == ht - 1);
        efe = ele && (ey == vt - 1);
        efc = (frames_raw(id) + base[id]) % 65536;
        chk($sformatf("d%0d_tick", id), int'(tk[id]), int'(etk));
        chk($sformatf("d%0d_x", id), int'(px[id]), ex);
        chk($sformatf("d%0d_y", id), int'(py[id]), ey);
        chk($sformatf("d%0d_hsync", id), int'(hs[id]), int'(ehs));
        chk($sformatf("d%0d_vsync", id), int'(vs[id]), int'(evs));
        chk($sformatf("d%0d_video_on", id), int'(vo[id]), int'(evo));
        chk($sformatf("d%0d_line_end", id), int'(le[id]), int'(ele));
        chk($sformatf("d%0d_frame_end", id), int'(fe[id]), int'(efe));
        chk($sformatf("d%0d_frame_count", id), int'(fc[id]), efc);
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) check_dut(i);
    endtask

    task automatic reset_literals();
        chk("rst_a_x", int'(px[0]), 799);
        chk("rst_a_y", int'(py[0]), 524);
        chk("rst_a_hsync", int'(hs[0]), 1);
        chk("rst_a_vsync", int'(vs[0]), 1);
        chk("rst_a_video_on", int'(vo[0]), 0);
        chk("rst_a_tick", int'(tk[0]), 0);
        chk("rst_a_line_end", int'(le[0]), 0);
        chk("rst_a_frame_end", int'(fe[0]), 0);
        chk("rst_a_frame_count", int'(fc[0]), 0);
        chk("rst_c_x", int'(px[2]), 24);
        chk("rst_c_y", int'(py[2]), 16);
        chk("rst_c_frame_count", int'(fc[2]), 0);
    endtask

    // First cycles after release, hand-computed.
    task automatic early_seq();
        for (int i = 1; i <= 4; i++) begin
            step();
            case (i)
                1: begin
                    chk("e1_a_tick", int'(tk[0]), 0);
                    chk("e1_b_tick", int'(tk[1]), 1);
                end
                2: begin
                    chk("e2_a_tick", int'(tk[0]), 0);
                    chk("e2_b_x", int'(px[1]), 0);
                    chk("e2_c_tick", int'(tk[2]), 1);
                end
                3: begin
                    chk("e3_a_tick", int'(tk[0]), 1);
                    chk("e3_a_x", int'(px[0]), 799);
                    chk("e3_a_y", int'(py[0]), 524);
                    chk("e3_a_line_end", int'(le[0]), 1);
                    chk("e3_a_frame_end", int'(fe[0]), 1);
                end
                default: begin
                    chk("e4_a_x", int'(px[0]), 0);
                    chk("e4_a_y", int'(py[0]), 0);
                    chk("e4_a_video_on", int'(vo[0]), 1);
                    chk("e4_a_hsync", int'(hs[0]), 1);
                    chk("e4_a_frame_count", int'(fc[0]), 0);
                end
            endcase
        end
    endtask

    initial begin
        int a_hlow, a_hfirst, a_hlast, a_vo, a_le, a_lex;
        int b_hlow, b_hfirst;
        int c_gap, c_gap_meas, c_vlow, c_fe_seen;
        int found;

        a_hlow = 0; a_hfirst = -1; a_hlast = -1; a_vo = 0; a_le = 0; a_lex = -1;
        b_hlow = 0; b_hfirst = -1;
        c_gap = 0; c_gap_meas = -1; c_vlow = 0; c_fe_seen = 0;

        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) base[i] = 0;
        repeat (3) step();
        reset_literals();
        rst = 1'b0;
        early_seq();

        // One full line of the default rasters, several frames of the tiny one.
        for (int i = 5; i <= 3400; i++) begin
            step();
            if (tk[0] && py[0] == 10'd0) begin
                if (!hs[0]) begin
                    if (a_hfirst < 0) a_hfirst = int'(px[0]);
                    a_hlast = int'(px[0]);
                    a_hlow++;
                end
                if (vo[0]) a_vo++;
                if (le[0]) begin a_le++; a_lex = int'(px[0]); end
            end
            if (tk[1] && py[1] == 10'd0 && !hs[1]) begin
                if (b_hfirst < 0) b_hfirst = int'(px[1]);
                b_hlow++;
            end
            if (tk[2]) begin
                if (c_fe_seen == 1 && !vs[2]) c_vlow++;
                c_gap++;
                if (fe[2]) begin
                    if (c_fe_seen == 1) c_gap_meas = c_gap;
                    c_fe_seen++;
                    c_gap = 0;
                end
            end
        end
        chk("a_hsync_low_ticks", a_hlow, 96);
        chk("a_hsync_first_x", a_hfirst, 656);
        chk("a_hsync_last_x", a_hlast, 751);
        chk("a_video_on_ticks", a_vo, 640);
        chk("a_line_end_count", a_le, 1);
        chk("a_line_end_x", a_lex, 799);
        chk("b_hsync_low_ticks", b_hlow, 96);
        chk("b_hsync_first_x", b_hfirst, 656);
        chk("c_ticks_per_frame", c_gap_meas, 425);
        chk("c_vsync_low_ticks", c_vlow, 50);
        chk("c_frame_count", int'(fc[2]), 2);
        chk("a_frame_count", int'(fc[0]), 0);

        // Fast-forward the tiny raster's frame counter to the wrap point.
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (px[2] == 10'd5) found = 1;
        end
        chk("c_force_point_found", found, 1);
        force dut_c.frame_cnt_q = 16'hFFFF;
        base[2] = (65535 - frames_raw(2) + 65536) % 65536;
        step();
        release dut_c.frame_cnt_q;
        step();
        chk("c_forced_count", int'(fc[2]), 65535);
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            step();
            if (fe[2]) found = 1;
        end
        chk("c_wrap_frame_end_seen", found, 1);
        step();
        chk("c_frame_count_wrap", int'(fc[2]), 0);

        // Asynchronous reset in the middle of a line, away from any clock edge.
        found = 0;
        for (int i = 0; i < 8000 && found == 0; i++) begin
            step();
            if (px[0] == 10'd320 && py[0] == 10'd1) found = 1;
        end
        chk("a_midreset_point_found", found, 1);
        #2;
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) base[i] = 0;
        #1;
        reset_literals();
        repeat (2) step();
        rst = 1'b0;
        early_seq();
        repeat (50) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal range 2..16.
REQ-002 Parameters H_DISPLAY/H_FRONT/H_SYNC/H_BACK, defaults 640/16/96/48: horizontal timing in pixels.
REQ-003 Parameters V_DISPLAY/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33: vertical timing in lines.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 reset  input  1  reset; asynchronous and active-high.
REQ-006 pixel_tick  output  1  one-clk strobe marking the pixel advance.
REQ-007 pixel_x  output  10  current horizontal count, 0..H_TOTAL-1, where H_TOTAL = 800 by default.
REQ-008 pixel_y  output  10  current vertical count, 0..V_TOTAL-1, where V_TOTAL = 525 by default.
REQ-009 hsync  output  1  horizontal sync, active-low.
REQ-010 vsync  output  1  vertical sync, active-low.
REQ-011 video_on  output  1  high while pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
REQ-012 line_end  output  1  one-clk strobe on the last pixel of each line.
REQ-013 frame_end  output  1  one-clk strobe on the last pixel of each frame.
REQ-014 frame_count  output  16  count of completed frames, for animation and game timing.

Function
REQ-015 The divider counter div_cnt SHALL run 0..CLK_DIV-1 and then wrap; pixel_tick = (div_cnt == CLK_DIV-1).
REQ-016 The counters h_cnt and v_cnt (driving pixel_x/pixel_y) SHALL update only on the clock edge that ends a pixel_tick cycle, and SHALL hold otherwise.
REQ-017 h_cnt SHALL increment by 1 per tick; at H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL increment.
REQ-018 v_cnt SHALL wrap from V_TOTAL-1 to 0 on the same tick that h_cnt wraps.
REQ-019 hsync SHALL be registered and low exactly when h_cnt is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751] by default.
REQ-020 vsync SHALL be registered and low exactly when v_cnt is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. [490,491] by default.
REQ-021 hsync, vsync and video_on SHALL be computed from the next-state counters so that they align with pixel_x/pixel_y in the same cycle; zero skew.
REQ-022 line_end = pixel_tick AND h_cnt == H_TOTAL-1.
REQ-023 frame_end = line_end AND v_cnt == V_TOTAL-1.
REQ-024 frame_count SHALL increment on frame_end, wrapping from 65535 to 0.
REQ-025 All widths SHALL be 10 bits unsigned; comparisons are unsigned with no truncation for the default totals (799 and 524 both fit in 10 bits).

Reset
REQ-026 While reset is high, the block SHALL set div_cnt=0, pixel_x=H_TOTAL-1 (799), pixel_y=V_TOTAL-1 (524), hsync=1, vsync=1, video_on=0 and frame_count=0.
REQ-027 As a consequence of REQ-026, pixel_tick, line_end and frame_end SHALL all be 0 during reset.
REQ-028 The reset state SHALL equal the last pixel of a frame, so the first tick after release wraps the counters to (0,0) without a frame_count increment.
REQ-029 An assertion of reset mid-frame SHALL return the block to the REQ-026 state immediately, without waiting for a clock edge.

Structure
REQ-030 The timing constants (display/porch/sync/total values) and CLK_DIV default SHALL live in the shared package vga_timing_pkg.
REQ-031 The divider SHALL be implemented as the sub-module pixel_tick_gen (inputs clk and reset, output tick), so pixel-rate logic in other blocks can reuse it.

Verification
REQ-032 Release reset, then count clk cycles -> first pixel_tick on clk 3 (0-based) and then every 4 clks; pixel_x/pixel_y go (799,524) -> (0,0); video_on=1; frame_count stays 0.
REQ-033 Run one full line -> hsync low for exactly 96 ticks, starting at pixel_x=656 and ending at 751; video_on high for 640 ticks; exactly one line_end, which occurs at pixel_x=799.
REQ-034 Run one full frame -> 420000 pixel_ticks between successive frame_end pulses (800 x 525); vsync low for 2 lines (y=490,491, i.e. 1600 ticks); frame_count = 1.
REQ-035 Run 65536 frames with a fast-forward force on frame_count=65535 -> the next frame_end wraps frame_count to 0.
REQ-036 Assert reset at (pixel_x=320, pixel_y=200) -> outputs reach the REQ-026 values with no clock edge; after release, the sequence is identical to REQ-032.
REQ-037 Build with CLK_DIV=2 -> a tick every 2 clks; the sync windows are unchanged in pixel units.
